rect_draw_arbiter: RTL

//   Shares one rectangle-fill engine between NUM_REQ requesters (background clear, player, obstacles, score).

---
 rtl/rect_draw_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rect_draw_arbiter.sv
// rect_draw_arbiter: round-robin front end for a shared rectangle-fill engine.
// Picks one requester at a time, latches its rectangle and colour, runs the
// engine's enable/finished handshake, and streams engine pixels to the VGA plot port.
module rect_draw_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int COORD_W  = 8,
    parameter int COLOUR_W = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*COORD_W-1:0]    req_x,
    input  logic [NUM_REQ*COORD_W-1:0]    req_y,
    input  logic [NUM_REQ*COORD_W-1:0]    req_w,
    input  logic [NUM_REQ*COORD_W-1:0]    req_h,
    input  logic [NUM_REQ*COLOUR_W-1:0]   req_colour,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic [COORD_W-1:0]            rect_x,
    output logic [COORD_W-1:0]            rect_y,
    output logic [COORD_W-1:0]            rect_w,
    output logic [COORD_W-1:0]            rect_h,
    output logic                          rect_enable,
    input  logic                          rect_finished,
    input  logic [COORD_W-1:0]            rect_x_out,
    input  logic [COORD_W-1:0]            rect_y_out,
    output logic [COORD_W-1:0]            vga_x,
    output logic [COORD_W-1:0]            vga_y,
    output logic [COLOUR_W-1:0]           vga_colour,
    output logic                          vga_plot
);

    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      ptr_next;
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [IDX_W:0]        cand;
    logic [COORD_W-1:0]    sel_x;
    logic [COORD_W-1:0]    sel_y;
    logic [COORD_W-1:0]    sel_w;
    logic [COORD_W-1:0]    sel_h;
    logic [COLOUR_W-1:0]   sel_colour;
    logic [COLOUR_W-1:0]   colour_q;
    logic                  zero_size;

    // Pixel coordinates come straight from the engine; colour is the latched one.
    assign vga_x      = rect_x_out;
    assign vga_y      = rect_y_out;
    assign vga_colour = colour_q;

    // After a job the pointer moves just past the requester that was served.
    assign ptr_next = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);

    // Round-robin search: first active request at or after ptr, wrapping mod NUM_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!pick_valid && req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Select the winning requester's slice of the packed rectangle/colour buses.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_w      = '0;
        sel_h      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_x      = req_x[i*COORD_W +: COORD_W];
                sel_y      = req_y[i*COORD_W +: COORD_W];
                sel_w      = req_w[i*COORD_W +: COORD_W];
                sel_h      = req_h[i*COORD_W +: COORD_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's job on acceptance, pulse grant, and advance ptr on release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr       <= '0;
            cur_idx   <= '0;
            rect_x    <= '0;
            rect_y    <= '0;
            rect_w    <= '0;
            rect_h    <= '0;
            colour_q  <= '0;
            zero_size <= 1'b0;
            grant     <= '0;
        end else begin
            grant <= '0;
            if (state == IDLE && pick_valid) begin
                cur_idx   <= pick_idx;
                rect_x    <= sel_x;
                rect_y    <= sel_y;
                rect_w    <= sel_w;
                rect_h    <= sel_h;
                colour_q  <= sel_colour;
                zero_size <= (sel_w == '0) || (sel_h == '0);
                grant     <= NUM_REQ'(1) << pick_idx;
            end
            if (state == RELEASE) begin
                ptr <= ptr_next;
            end
        end
    end

    // Next state and handshake outputs; a zero-size job spends one DRAW cycle with the engine held off.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        rect_enable = 1'b0;
        vga_plot    = 1'b0;
        done        = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                busy        = 1'b1;
                rect_enable = !zero_size;
                vga_plot    = !zero_size && !rect_finished;
                if (zero_size || rect_finished) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                busy       = 1'b1;
                done       = NUM_REQ'(1) << cur_idx;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
